// File: rtl/mips_pkg.sv
// Shared constants and helpers for the MIPS32 register bank and its pending-write scoreboard.
package mips_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int R0_IDX     = 0;

  typedef enum logic [1:0] {
    PC_HOLD  = 2'd0,
    PC_INC   = 2'd1,
    PC_DEC   = 2'd2,
    PC_UNDER = 2'd3
  } pend_op_e;

  function automatic int unsigned pend_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/mips_pend_ctr.sv
// Saturating pending-write counter for one register: issue increments, retire decrements.
module mips_pend_ctr
  import mips_pkg::*;
#(
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_i,
  input  logic              dec_i,
  output logic [PEND_W-1:0] cnt_o,
  output logic              err_o
);

  localparam logic [PEND_W-1:0] CNT_MAX = PEND_W'(pend_max(PEND_W));

  logic [PEND_W-1:0] cnt_q, cnt_d;
  pend_op_e          op;

  // Simultaneous issue and retire cancel out, which also covers the 0->0 case.
  always_comb begin
    op = PC_HOLD;
    case ({inc_i, dec_i})
      2'b10:   op = PC_INC;
      2'b01:   op = (cnt_q == '0) ? PC_UNDER : PC_DEC;
      default: op = PC_HOLD;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    case (op)
      PC_INC:  if (cnt_q != CNT_MAX) cnt_d = cnt_q + PEND_W'(1);
      PC_DEC:  cnt_d = cnt_q - PEND_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign err_o = (op == PC_UNDER);

endmodule

// File: rtl/mips_regfile_sb.sv
// MIPS32 register bank with write-through read bypass and a per-register pending-write
// scoreboard that lets ID stall on operands still in flight.
module mips_regfile_sb
  import mips_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int PEND_W   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_dst,
  output logic                     iss_ready,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  output logic                     sb_err
);

  localparam int                DEPTH   = 1 << ADDR_W;
  localparam logic [PEND_W-1:0] CNT_MAX = PEND_W'(pend_max(PEND_W));
  localparam logic [ADDR_W-1:0] R0      = ADDR_W'(R0_IDX);
  localparam logic              HAS_R0  = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [PEND_W-1:0] cnt    [DEPTH];
  logic [DEPTH-1:0]  err_vec;
  logic              sb_err_q, sb_err_d;
  logic              wb_wr, iss_zero, iss_acc;

  assign wb_wr    = wb_en && !(HAS_R0 && wb_addr == R0);
  assign iss_zero = HAS_R0 && iss_dst == R0;

  // A retire to the same index this cycle frees a slot, so a saturated counter still accepts.
  assign iss_ready = (cnt[iss_dst] != CNT_MAX) || iss_zero || (wb_en && wb_addr == iss_dst);
  assign iss_acc   = iss_valid && iss_ready && !iss_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) regs_q[r] <= '0;
    end else if (wb_wr) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  for (genvar r = 0; r < DEPTH; r++) begin : g_ctr
    mips_pend_ctr #(.PEND_W(PEND_W)) u_ctr (
      .clk   (clk),
      .rst   (rst),
      .inc_i (iss_acc && iss_dst == ADDR_W'(r)),
      .dec_i (wb_wr && wb_addr == ADDR_W'(r)),
      .cnt_o (cnt[r]),
      .err_o (err_vec[r])
    );
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              zero, hit;
    logic [PEND_W-1:0] c;

    assign a    = rd_addr[i*ADDR_W +: ADDR_W];
    assign zero = HAS_R0 && a == R0;
    assign hit  = wb_en && !rst && wb_addr == a;
    assign c    = cnt[a];

    assign rd_data[i*DATA_W +: DATA_W] = zero ? '0 : (hit ? wb_data : regs_q[a]);
    // Busy is the count after this cycle's retire, saturating at zero.
    assign rd_busy[i] = !zero && ((c > PEND_W'(1)) || (c == PEND_W'(1) && !hit));
  end

  assign sb_err_d = sb_err_q || (|err_vec);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sb_err_q <= 1'b0;
    else     sb_err_q <= sb_err_d;
  end

  assign sb_err = sb_err_q;

endmodule

// File: tb/tb_mips_regfile_sb.sv
// Directed and randomized bench for mips_regfile_sb against an array-based reference model.
module tb_mips_regfile_sb;

  logic        clk;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        iss_valid;
  logic [4:0]  iss_dst;
  logic        iss_ready;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        sb_err;

  mips_regfile_sb dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .iss_valid (iss_valid),
    .iss_dst   (iss_dst),
    .iss_ready (iss_ready),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .sb_err    (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] mreg [32];
  int          mcnt [32];
  bit          merr;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin
      mreg[r] = '0;
      mcnt[r] = 0;
    end
    merr = 1'b0;
  endtask

  task automatic set_in(input bit iv, input int idst, input bit we, input int wa,
                        input logic [31:0] wd, input int ra0, input int ra1);
    iss_valid = iv;
    iss_dst   = 5'(idst);
    wb_en     = we;
    wb_addr   = 5'(wa);
    wb_data   = wd;
    rd_addr   = {5'(ra1), 5'(ra0)};
  endtask

  // Compare every output against the model, then advance model and DUT by one clock.
  task automatic cycle();
    int          a, pend, d;
    bit          hit, exp_ready, acc;
    logic [31:0] exp_data;
    #2;
    for (int i = 0; i < 2; i++) begin
      a   = int'(rd_addr[i*5 +: 5]);
      hit = wb_en && wb_addr == 5'(a);
      if (a == 0)   exp_data = '0;
      else if (hit) exp_data = wb_data;
      else          exp_data = mreg[a];
      pend = mcnt[a] - (hit ? 1 : 0);
      if (pend < 0 || a == 0) pend = 0;
      chk($sformatf("rd_data%0d", i), rd_data[i*32 +: 32], exp_data);
      chk($sformatf("rd_busy%0d", i), 32'(rd_busy[i]), 32'(pend != 0));
    end
    d = int'(iss_dst);
    exp_ready = (d == 0) || (mcnt[d] < 3) || (wb_en && int'(wb_addr) == d);
    chk("iss_ready", 32'(iss_ready), 32'(exp_ready));
    chk("sb_err", 32'(sb_err), 32'(merr));
    @(posedge clk);
    acc = iss_valid && exp_ready && d != 0;
    if (wb_en && wb_addr != 0) begin
      mreg[wb_addr] = wb_data;
      if (acc && int'(wb_addr) == d) begin
        // issue and retire cancel
      end else if (mcnt[wb_addr] > 0) mcnt[wb_addr]--;
      else merr = 1'b1;
      if (acc && int'(wb_addr) != d) mcnt[d]++;
    end else if (acc) begin
      mcnt[d]++;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_rd0", rd_data[31:0], 32'd0);
    chk("rst_rd1", rd_data[63:32], 32'd0);
    chk("rst_busy", 32'(rd_busy), 32'd0);
    chk("rst_err", 32'(sb_err), 32'd0);
    chk("rst_ready", 32'(iss_ready), 32'd1);
    model_clear();
    @(posedge clk);
    #1;
    set_in(0, 0, 0, 0, 0, 5, 0);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    // Reset mid-run after R5=7
    set_in(1, 5, 0, 0, 0, 0, 0); cycle();
    set_in(0, 0, 1, 5, 7, 0, 0); cycle();
    set_in(0, 0, 0, 0, 0, 5, 0); #1 chk("r5_is_7", rd_data[31:0], 32'd7); cycle();
    set_in(1, 5, 1, 5, 32'd77, 5, 5);
    do_reset();
    chk("r5_after_rst", rd_data[31:0], 32'd0);
    cycle();

    // Bypass
    set_in(1, 4, 0, 0, 0, 0, 0); cycle();
    set_in(0, 0, 1, 4, 32'd30, 4, 0); #1 chk("bypass", rd_data[31:0], 32'd30); cycle();
    set_in(0, 0, 0, 0, 0, 4, 0); #1 chk("storage", rd_data[31:0], 32'd30); cycle();

    // Scoreboard chain, no dummy ORs
    set_in(1, 1, 0, 0, 0, 0, 0);       cycle();
    set_in(1, 2, 1, 1, 32'd10, 1, 0);  cycle();
    set_in(1, 3, 1, 2, 32'd20, 1, 2);  cycle();
    set_in(0, 0, 1, 3, 32'd25, 1, 2);  cycle();
    set_in(1, 4, 0, 0, 0, 0, 0);       cycle();
    set_in(1, 5, 0, 0, 0, 4, 5);
    #1 chk("busy_r4", 32'(rd_busy[0]), 32'd1);
    chk("iss_same_cyc", 32'(rd_busy[1]), 32'd0);
    cycle();
    set_in(0, 0, 1, 4, 32'd30, 4, 5);
    #1 chk("r4_clear_wb", 32'(rd_busy[0]), 32'd0);
    chk("busy_r5", 32'(rd_busy[1]), 32'd1);
    cycle();
    set_in(0, 0, 1, 5, 32'd55, 5, 4);
    #1 chk("r5_clear_wb", 32'(rd_busy[0]), 32'd0);
    cycle();
    for (int r = 1; r <= 5; r++) begin
      logic [31:0] prog [5];
      prog = '{32'd10, 32'd20, 32'd25, 32'd30, 32'd55};
      set_in(0, 0, 0, 0, 0, r, r);
      #1 chk($sformatf("prog_r%0d", r), rd_data[31:0], prog[r-1]);
      chk($sformatf("prog2_r%0d", r), rd_data[63:32], prog[r-1]);
      cycle();
    end

    // Saturation
    for (int k = 0; k < 3; k++) begin
      set_in(1, 7, 0, 0, 0, 7, 0); cycle();
    end
    set_in(1, 7, 0, 0, 0, 7, 0); #1 chk("sat_refuse", 32'(iss_ready), 32'd0); cycle();
    set_in(1, 7, 1, 7, 32'd123, 7, 0); #1 chk("sat_retire_ok", 32'(iss_ready), 32'd1); cycle();
    set_in(1, 7, 0, 0, 0, 7, 0);
    #1 chk("sat_still3", 32'(iss_ready), 32'd0);
    chk("sat_busy", 32'(rd_busy[0]), 32'd1);
    cycle();

    // R0 handling
    set_in(1, 0, 1, 0, 32'd99, 0, 0);
    #1 chk("r0_rd", rd_data[31:0], 32'd0);
    chk("r0_busy", 32'(rd_busy[0]), 32'd0);
    chk("r0_ready", 32'(iss_ready), 32'd1);
    cycle();
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1 chk("r0_err", 32'(sb_err), 32'd0);
    chk("r0_rd_after", rd_data[31:0], 32'd0);
    cycle();

    // Underflow
    set_in(0, 0, 1, 9, 32'd1, 9, 0); cycle();
    set_in(0, 0, 0, 0, 0, 9, 0);
    #1 chk("uf_data", rd_data[31:0], 32'd1);
    chk("uf_err", 32'(sb_err), 32'd1);
    cycle();
    for (int k = 0; k < 4; k++) cycle();
    chk("uf_sticky", 32'(sb_err), 32'd1);
    do_reset();

    // Randomized traffic on a small index window to force collisions
    for (int n = 0; n < 2000; n++) begin
      set_in(bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
             bit'($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)), $urandom,
             int'($urandom_range(0, 7)), int'($urandom_range(0, 31)));
      cycle();
      if (n == 1000) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
